// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  localparam logic [PC_W-1:0] PC_INC = 64'd4;

  localparam logic [INSTR_W-1:0] IF_ID_INSTR_RST = '0;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_pc(
    input logic [PC_W-1:0] a
  );
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem address/data, hazard controls and IF/ID outputs.
// The fault signal exists only when FETCH_ALIGN_CHECK_EN is defined.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic [PC_W-1:0]    read_address;
  logic [INSTR_W-1:0] instruction;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_target;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic               if_id_valid;
  logic               halted;
  logic [CNT_W-1:0]   fetch_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               fault;
`endif

  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    output fault,
`endif
    output read_address,
    output if_id_instr,
    output if_id_pc,
    output if_id_valid,
    output halted,
    output fetch_count,
    input  instruction,
    input  stall,
    input  redirect_valid,
    input  redirect_target
  );

  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    input  fault,
`endif
    input  read_address,
    input  if_id_instr,
    input  if_id_pc,
    input  if_id_valid,
    input  halted,
    input  fetch_count,
    output instruction,
    output stall,
    output redirect_valid,
    output redirect_target
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset, squash (drop valid, keep payload),
// load, otherwise hold.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               squash_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= IF_ID_INSTR_RST;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (squash_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch stage: PC, FETCH/HALT control and delivered-instr counter.
// Optional misaligned-redirect fault: define FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_BYTES = 128,
  parameter int          CNT_W      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam logic [PC_W-1:0] LAST_PC =
    PC_W'(IMEM_BYTES - 4);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             halted_q, halted_d;
  logic             load, squash;
  logic [PC_W-1:0]  tgt;
  logic             tgt_ok;
  logic             misalign;
  logic             blocked;

  assign tgt    = align_pc(bus.redirect_target);
  assign tgt_ok = tgt <= LAST_PC;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign misalign  = |bus.redirect_target[1:0];
  assign blocked   = fault_q;
  assign bus.fault = fault_q;
`else
  assign misalign = 1'b0;
  assign blocked  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    load     = 1'b0;
    squash   = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d  = fault_q;
`endif
    unique case (state_q)
      FETCH: begin
        if (bus.redirect_valid) begin
          squash = 1'b1;
          if (misalign) begin
            state_d  = HALT;
            halted_d = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d  = 1'b1;
`endif
          end else begin
            pc_d = tgt;
          end
        end else if (!bus.stall) begin
          if (pc_q > LAST_PC) begin
            state_d  = HALT;
            halted_d = 1'b1;
            squash   = 1'b1;
          end else begin
            load  = 1'b1;
            pc_d  = pc_q + PC_INC;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          end
        end
      end
      HALT: begin
        squash = 1'b1;
        if (bus.redirect_valid && !blocked) begin
          if (misalign) begin
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d = 1'b1;
`endif
          end else begin
            pc_d = tgt;
            if (tgt_ok) begin
              state_d  = FETCH;
              halted_d = 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      halted_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  if_id_reg u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .squash_i (squash),
    .instr_i  (bus.instruction),
    .pc_i     (pc_q),
    .instr_o  (bus.if_id_instr),
    .pc_o     (bus.if_id_pc),
    .valid_o  (bus.if_id_valid)
  );

  assign bus.read_address = pc_q;
  assign bus.halted       = halted_q;
  assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random
// stall/redirect/reset traffic against a behavioural reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int IMEM  = 128;
  localparam int CNT_W = 32;
  localparam logic [63:0] LAST = 64'(IMEM - 4);
`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if #(.CNT_W(CNT_W)) bus ();

  fetch_stage #(
    .RESET_PC   (64'h0),
    .IMEM_BYTES (IMEM),
    .CNT_W      (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [IMEM/4];
  logic [31:0] w [4];

  function automatic logic [31:0] rd(input logic [63:0] a);
    if (a < 64'(IMEM)) return mem[int'(a >> 2)];
    return 32'h0;
  endfunction

  assign bus.instruction = rd(bus.read_address);

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // Reference model: tracks what the stage must look like after each edge.
  logic [63:0] m_pc, m_ipc, m_at;
  logic [31:0] m_instr, m_cnt;
  logic        m_valid, m_halt, m_fault, m_bad;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 0; m_ipc = 0; m_instr = 0; m_cnt = 0;
      m_valid = 0; m_halt = 0; m_fault = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      m_at  = bus.redirect_target & ~64'd3;
      m_bad = ALN && (bus.redirect_target[1:0] != 2'b00);
      if (!m_halt) begin
        if (bus.redirect_valid) begin
          m_valid = 0;
          if (m_bad) begin
            m_fault = 1; m_halt = 1;
          end else m_pc = m_at;
        end else if (!bus.stall) begin
          if (m_pc > LAST) begin
            m_halt = 1; m_valid = 0;
          end else begin
            m_instr = rd(m_pc);
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          end
        end
      end else begin
        m_valid = 0;
        if (bus.redirect_valid && !m_fault) begin
          if (m_bad) m_fault = 1;
          else begin
            m_pc = m_at;
            if (m_at <= LAST) m_halt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      cmp("m.read_address", bus.read_address, m_pc);
      cmp("m.if_id_instr", 64'(bus.if_id_instr), 64'(m_instr));
      cmp("m.if_id_pc", bus.if_id_pc, m_ipc);
      cmp("m.if_id_valid", 64'(bus.if_id_valid), 64'(m_valid));
      cmp("m.halted", 64'(bus.halted), 64'(m_halt));
      cmp("m.fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
`ifdef FETCH_ALIGN_CHECK_EN
      cmp("m.fault", 64'(bus.fault), 64'(m_fault));
`endif
    end
  end

  task automatic cyc(input logic r, input logic st,
                     input logic rv, input logic [63:0] t);
    rst_n               = r;
    bus.stall           = st;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    w[0] = 32'h8B1F03E5; w[1] = 32'hF84000A4;
    w[2] = 32'h8B040086; w[3] = 32'hF80010A6;
    for (int i = 0; i < IMEM/4; i++)
      mem[i] = (i < 4) ? w[i] : $urandom;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = '0;

    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    cmp("rst.addr", bus.read_address, 64'h0);
    cmp("rst.valid", 64'(bus.if_id_valid), 64'h0);
    cmp("rst.instr", 64'(bus.if_id_instr), 64'h0);
    cmp("rst.cnt", 64'(bus.fetch_count), 64'h0);
    cmp("rst.halted", 64'(bus.halted), 64'h0);

    for (int i = 0; i < 4; i++) begin
      run(1);
      cmp("seq.instr", 64'(bus.if_id_instr), 64'(w[i]));
      cmp("seq.pc", bus.if_id_pc, 64'(4 * i));
    end
    cmp("seq.cnt", 64'(bus.fetch_count), 64'd4);

    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    run(2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 64'h0);
      cmp("stall.addr", bus.read_address, 64'd8);
      cmp("stall.instr", 64'(bus.if_id_instr), 64'hF84000A4);
      cmp("stall.cnt", 64'(bus.fetch_count), 64'd2);
    end
    run(1);
    cmp("rel.instr", 64'(bus.if_id_instr), 64'h8B040086);
    cyc(1'b1, 1'b1, 1'b1, 64'd4);
    cmp("redir.addr", bus.read_address, 64'd4);
    cmp("redir.valid", 64'(bus.if_id_valid), 64'h0);
    cmp("redir.hold", bus.if_id_pc, 64'd8);
    run(1);
    cmp("redir.instr", 64'(bus.if_id_instr), 64'hF84000A4);
    cmp("redir.pc", bus.if_id_pc, 64'd4);

    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    run(33);
    cmp("end.halted", 64'(bus.halted), 64'h1);
    cmp("end.valid", 64'(bus.if_id_valid), 64'h0);
    cmp("end.cnt", 64'(bus.fetch_count), 64'd32);
    cmp("end.addr", bus.read_address, 64'd128);
    cyc(1'b1, 1'b1, 1'b0, 64'h0);
    cmp("end.stall", 64'(bus.halted), 64'h1);
    cyc(1'b1, 1'b0, 1'b1, 64'h0);
    cmp("resume.halted", 64'(bus.halted), 64'h0);
    cmp("resume.addr", bus.read_address, 64'h0);
    run(1);
    cmp("resume.instr", 64'(bus.if_id_instr), 64'(w[0]));

    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    run(5);
    cmp("mid.addr", bus.read_address, 64'd20);
    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    cmp("mid.rst.addr", bus.read_address, 64'h0);
    cmp("mid.rst.valid", 64'(bus.if_id_valid), 64'h0);
    cmp("mid.rst.cnt", 64'(bus.fetch_count), 64'h0);

    run(2);
    cyc(1'b1, 1'b0, 1'b1, 64'd6);
`ifdef FETCH_ALIGN_CHECK_EN
    cmp("aln.addr", bus.read_address, 64'd8);
    cmp("aln.fault", 64'(bus.fault), 64'h1);
    cmp("aln.halted", 64'(bus.halted), 64'h1);
    cyc(1'b1, 1'b0, 1'b1, 64'h0);
    cmp("aln.ignore", bus.read_address, 64'd8);
`else
    cmp("aln.addr", bus.read_address, 64'd4);
    run(1);
    cmp("aln.instr", 64'(bus.if_id_instr), 64'hF84000A4);
`endif

    cyc(1'b0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] t;
      case ($urandom_range(0, 9))
        0: t = 64'hFFFF_FFFF_FFFF_FFFC;
        1: t = 64'd124;
        default: begin
          t = 64'($urandom_range(0, 35)) * 64'd4;
          if ($urandom_range(0, 7) == 0)
            t = t + 64'($urandom_range(1, 3));
        end
      endcase
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 core, directly upstream of instruction memory.
- Owns the 64-bit program counter and drives the memory's byte read address.
- Captures the returned 32-bit little-endian word into the IF/ID pipeline register, with valid, stall and redirect handling.
- Halts cleanly when the PC runs past the populated memory range.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- IMEM_BYTES, 128, instruction memory size in bytes; the last legal fetch address is IMEM_BYTES-4.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- read_address  output  64  byte address to instruction memory; equals the pc register (combinational from the register).
- instruction  input  32  word returned combinationally by instruction memory for read_address.
- stall  input  1  hazard-unit request to hold the PC and IF/ID.
- redirect_valid  input  1  taken branch or jump resolved downstream.
- redirect_target  input  64  absolute byte target for the redirect.
- if_id_instr  output  32  captured instruction.
- if_id_pc  output  64  PC of the captured instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch has stopped at end of memory or on a fault.
- fetch_count  output  CNT_W  number of instructions delivered.

Behaviour:
- Reset (rst_n=0 at a posedge): pc=RESET_PC, if_id_instr=0, if_id_pc=0, if_id_valid=0, halted=0, fetch_count=0, state=FETCH. Reset mid-operation discards everything the same way.
- States: FETCH, HALT.
- FETCH, priority order:
  - redirect_valid=1 (overrides stall):
    - pc<=target with the low 2 bits forced to 0.
    - if_id_valid<=0; the current-cycle word is wrong-path and is squashed.
    - if_id_instr and if_id_pc hold.
  - stall=1: pc and all IF/ID outputs hold; fetch_count holds.
  - pc > IMEM_BYTES-4:
    - state<=HALT, halted<=1, if_id_valid<=0.
    - pc holds.
  - Otherwise:
    - if_id_instr<=instruction, if_id_pc<=pc, if_id_valid<=1.
    - pc<=pc+4, computed modulo 2^64.
    - fetch_count<=fetch_count+1, saturating at all-ones.
- HALT:
  - read_address holds, if_id_valid=0.
  - A redirect whose aligned target is <= IMEM_BYTES-4 sets pc<=target, halted<=0, state<=FETCH.
  - A stall has no effect.
  - An out-of-range redirect loads pc but stays in HALT.
- Latency: an instruction at address A appears on if_id_* one cycle after pc==A. After a redirect there is a one-cycle bubble.
- Simultaneous redirect and end-of-memory: redirect wins.
- A pc wrap past 2^64-4 lands out of range and halts.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fault (1 bit, reset 0).
  - A redirect with redirect_target[1:0]!=0, in either state, sets fault<=1, halted<=1, state<=HALT, if_id_valid<=0, and leaves pc unchanged.
  - fault clears only on reset.
  - Subsequent valid redirects are ignored while fault=1.
- Undefined: no fault port; low bits are silently masked as described above.

Decomposition:
- fetch_pkg:
  - State enum FETCH/HALT.
  - Constants INSTR_W=32, PC_W=64, PC_INC=4.
  - Reset value for if_id_instr.
- One sub-module, if_id_reg:
  - Holds instr, pc and valid, with load, hold and squash controls and the synchronous active-low reset.
  - fetch_stage owns the PC, the FSM and the counter.

Test Plan:
- Preload memory words 0x8B1F03E5, 0xF84000A4, 0x8B040086, 0xF80010A6 at bytes 0/4/8/12; release reset, no stall -> if_id_instr shows these on cycles 1-4, if_id_pc=0,4,8,12, fetch_count=4.
- stall=1 for 3 cycles while pc=8 -> read_address stays 8, if_id_instr stays 0xF84000A4, fetch_count unchanged; on release, 0x8B040086 is captured.
- redirect_valid=1 with target=4, asserted together with stall=1 while pc=12 -> next cycle pc=4 and if_id_valid=0; the following cycle if_id_instr=0xF84000A4 and if_id_pc=4.
- Run sequentially to pc=128 with IMEM_BYTES=128 -> halted=1 and if_id_valid=0 from that edge; fetch_count=32, pc holds 128. Then redirect target=0 -> halted=0, fetch resumes at 0.
- Assert rst_n=0 for one cycle mid-run at pc=20 -> all outputs at reset values the next cycle and pc=RESET_PC.
- With FETCH_ALIGN_CHECK_EN, redirect target=6 -> fault=1, halted=1, pc unchanged. Without the macro -> pc=4 and fetch continues.
